// File: rtl/cordic_dispatch_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cordic_dispatch_fifo
// Description : Issue stage for the cosine CORDIC core. Buffers float angle
//               requests in a small FIFO, launches the core one operation at
//               a time with a start strobe, waits for done (with a watchdog)
//               and presents the result on a valid/ready output port.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_dispatch_fifo #(
  parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
  parameter int AW      = 2,   // log2(DEPTH)
  parameter int TIMEOUT = 32   // WAIT cycles before the core is declared hung
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          clk_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          core_start,
  output logic [31:0]   core_dataa,
  input  logic          core_done,
  input  logic [31:0]   core_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_err,
  output logic          timeout_seen,
  output logic [AW:0]   fifo_count,
  output logic          busy
);

  localparam int             CW           = $clog2(TIMEOUT);
  localparam logic [1:0]     c_st_idle    = 2'd0;
  localparam logic [1:0]     c_st_wait    = 2'd1;
  localparam logic [1:0]     c_st_drain   = 2'd2;
  localparam logic [AW:0]    c_full_count = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]  c_cnt_last   = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          core_start_q, core_start_d;
  logic [31:0]   core_dataa_q, core_dataa_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_err_q, out_err_d;
  logic          timeout_seen_q, timeout_seen_d;
  logic [31:0]   mem_q [DEPTH];

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_launch;

  // A full FIFO refuses a push even if a launch pops in the same cycle,
  // so in_ready never depends on the FSM.
  assign w_full   = (count_q == c_full_count);
  assign w_empty  = (count_q == '0);
  assign w_push   = clk_en && in_valid && !w_full;
  assign w_launch = clk_en && (state_q == c_st_idle) && !w_empty;

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_launch) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_launch})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Launch / wait / drain sequencing with watchdog; everything holds while
  // clk_en is low.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    core_start_d   = core_start_q;
    core_dataa_d   = core_dataa_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_err_d      = out_err_q;
    timeout_seen_d = timeout_seen_q;
    if (clk_en) begin
      // Start is a single-cycle strobe: high only after a launch edge.
      core_start_d = w_launch;
      case (state_q)
        c_st_idle: begin
          if (w_launch) begin
            core_dataa_d = mem_q[rd_ptr_q];
            cnt_d        = '0;
            state_d      = c_st_wait;
          end
        end
        c_st_wait: begin
          cnt_d = cnt_q + 1'b1;
          // On the first WAIT edge the core has not yet seen start, so a
          // high done is left over from the previous operation.
          if (core_done && (cnt_q != '0)) begin
            out_data_d  = core_result;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = c_st_drain;
          end else if (cnt_q == c_cnt_last) begin
            out_data_d     = 32'h0;
            out_err_d      = 1'b1;
            out_valid_d    = 1'b1;
            timeout_seen_d = 1'b1;
            state_d        = c_st_drain;
          end
        end
        c_st_drain: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = c_st_idle;
          end
        end
        default: begin
          state_d = c_st_idle;
        end
      endcase
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state_q        <= c_st_idle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      cnt_q          <= '0;
      core_start_q   <= 1'b0;
      core_dataa_q   <= 32'h0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 32'h0;
      out_err_q      <= 1'b0;
      timeout_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      cnt_q          <= cnt_d;
      core_start_q   <= core_start_d;
      core_dataa_q   <= core_dataa_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_err_q      <= out_err_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready     = !w_full;
  assign core_start   = core_start_q;
  assign core_dataa   = core_dataa_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_err      = out_err_q;
  assign timeout_seen = timeout_seen_q;
  assign fifo_count   = count_q;
  assign busy         = (state_q != c_st_idle) || !w_empty;

endmodule
`default_nettype wire
